// File: rtl/uart_tx_board.sv
// rtl/uart_tx_board.sv - 16x-oversampled UART transmitter with free-running baud generator and TX FIFO
// Optional even parity bit between data and stop: define UART_TX_PARITY_EN.
module uart_tx_board #(
    parameter int DBIT        = 8,
    parameter int SB_TICK     = 16,
    parameter int FINAL_VALUE = 650,
    parameter int ADDR_W      = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wr_en,
    input  logic [DBIT-1:0] i_tx_din,
    output logic            o_tx_full,
    output logic            o_tx_empty,
    output logic            o_tx_busy,
    output logic            o_tx_done_tick,
    output logic            o_tx
);
    localparam int S_W   = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int DEPTH = 1 << ADDR_W;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [10:0] r_baud;
    logic        w_s_tick;

    assign w_s_tick = (r_baud == 11'(FINAL_VALUE));

    always_ff @(posedge i_clk) begin
        if (i_reset || w_s_tick) r_baud <= '0;
        else                     r_baud <= r_baud + 11'd1;
    end

    logic [DBIT-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0] r_rp, r_wp, w_rp_next, w_wp_next;
    logic              r_full, r_empty;
    logic              w_push, w_pop;

    // A full FIFO still accepts a push in the cycle the FSM pops the head.
    assign w_push    = i_wr_en && (!r_full || w_pop);
    assign w_rp_next = r_rp + ADDR_W'(1);
    assign w_wp_next = r_wp + ADDR_W'(1);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_tx_din;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rp    <= '0;
            r_wp    <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_wp    <= w_wp_next;
                    r_empty <= 1'b0;
                    r_full  <= (w_wp_next == r_rp);
                end
                2'b01: begin
                    r_rp    <= w_rp_next;
                    r_full  <= 1'b0;
                    r_empty <= (w_rp_next == r_wp);
                end
                2'b11: begin
                    r_rp <= w_rp_next;
                    r_wp <= w_wp_next;
                end
                default: ;
            endcase
        end
    end

    state_t          r_state, w_state_next;
    logic [S_W-1:0]  r_s, w_s_next;
    logic [N_W-1:0]  r_n, w_n_next;
    logic [DBIT-1:0] r_b, w_b_next;
    logic            r_tx, w_tx, w_done;
`ifdef UART_TX_PARITY_EN
    logic            r_par, w_par_next;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            r_tx    <= w_tx;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_next;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
`ifdef UART_TX_PARITY_EN
        w_par_next   = r_par;
`endif
        case (r_state)
            IDLE: if (!r_empty) begin
                w_state_next = START;
                w_s_next     = '0;
                w_b_next     = r_mem[r_rp];
`ifdef UART_TX_PARITY_EN
                w_par_next   = ^r_mem[r_rp];
`endif
            end
            START: if (w_s_tick) begin
                if (r_s == S_W'(15)) begin
                    w_state_next = DATA;
                    w_s_next     = '0;
                    w_n_next     = '0;
                end else w_s_next = r_s + S_W'(1);
            end
            DATA: if (w_s_tick) begin
                if (r_s == S_W'(15)) begin
                    w_s_next = '0;
                    w_b_next = r_b >> 1;
                    if (r_n == N_W'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else w_n_next = r_n + N_W'(1);
                end else w_s_next = r_s + S_W'(1);
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (w_s_tick) begin
                if (r_s == S_W'(15)) begin
                    w_state_next = STOP;
                    w_s_next     = '0;
                end else w_s_next = r_s + S_W'(1);
            end
`endif
            STOP: if (w_s_tick) begin
                if (r_s == S_W'(SB_TICK - 1)) w_state_next = IDLE;
                else                          w_s_next     = r_s + S_W'(1);
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_tx   = 1'b1;
        w_done = 1'b0;
        w_pop  = 1'b0;
        case (r_state)
            IDLE:   w_pop  = !r_empty;
            START:  w_tx   = 1'b0;
            DATA:   w_tx   = r_b[0];
`ifdef UART_TX_PARITY_EN
            PARITY: w_tx   = r_par;
`endif
            STOP:   w_done = w_s_tick && (r_s == S_W'(SB_TICK - 1));
            default: ;
        endcase
    end

    assign o_tx           = r_tx;
    assign o_tx_done_tick = w_done;
    assign o_tx_busy      = (r_state != IDLE);
    assign o_tx_full      = r_full;
    assign o_tx_empty     = r_empty;
endmodule

// File: tb/tb_uart_tx_board.sv
// tb/tb_uart_tx_board.sv - directed and random frame checks of uart_tx_board against a line-level frame model
// Frame model follows UART_TX_PARITY_EN when it is defined for the build.
module tb_uart_tx_board;
    localparam int DBIT   = 8;
    localparam int SBT    = 16;
    localparam int FV     = 3;
    localparam int AW     = 2;
    localparam int BITCLK = 16 * (FV + 1);
`ifdef UART_TX_PARITY_EN
    localparam int NB = DBIT + 1;
`else
    localparam int NB = DBIT;
`endif

    logic       clk = 1'b0;
    logic       reset, wr_en;
    logic [7:0] din;
    logic       tx_full, tx_empty, tx_busy, tx_done, tx;

    always #5 clk = ~clk;

    uart_tx_board #(.DBIT(DBIT), .SB_TICK(SBT), .FINAL_VALUE(FV), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_tx_din(din),
        .o_tx_full(tx_full), .o_tx_empty(tx_empty), .o_tx_busy(tx_busy),
        .o_tx_done_tick(tx_done), .o_tx(tx)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Line word for a byte: data bits LSB first, then even parity when enabled.
    function automatic int frame_word(input int b);
        int w;
        int ones;
        w    = b & 255;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += (b >> i) & 1;
`ifdef UART_TX_PARITY_EN
        w = w | ((ones % 2) << 8);
`endif
        return w;
    endfunction

    // High samples before the next start bit: ones ending the frame, stop bit, 1 clk idle.
    function automatic int b2b_gap(input int prev_b);
        int w;
        int run;
        w   = frame_word(prev_b);
        run = 0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (((w >> i) & 1) == 0) break;
            run++;
        end
        return 65 + BITCLK * run;
    endfunction

    int  done_cnt = 0, done_wide = 0, frame_err = 0, frames = 0;
    int  hi_run = 0, dec_cnt = 0, dec_word = 0, k;
    bit  dec_on = 0, done_prev = 0, rec = 0;
    int  rx_q[$];
    int  gap_q[$];
    bit  trace[$];

    // Line monitor: mid-bit sampling decoder, gap measurement and done-pulse bookkeeping.
    always @(negedge clk) begin
        if (rec) trace.push_back(tx === 1'b1);
        if (tx_done === 1'b1) begin
            done_cnt++;
            if (done_prev) done_wide++;
        end
        done_prev = (tx_done === 1'b1);
        if (reset === 1'b1) begin
            dec_on = 0;
        end else if (dec_on) begin
            dec_cnt++;
            if (dec_cnt == BITCLK / 2) begin
                if (tx !== 1'b0) frame_err++;
            end else if (dec_cnt > BITCLK / 2 && (dec_cnt - BITCLK / 2) % BITCLK == 0) begin
                k = (dec_cnt - BITCLK / 2) / BITCLK;
                if (k <= NB) dec_word = dec_word | (int'(tx === 1'b1) << (k - 1));
                else begin
                    if (tx !== 1'b1) frame_err++;
                    rx_q.push_back(dec_word);
                    frames++;
                    dec_on = 0;
                end
            end
        end else if (tx === 1'b0) begin
            dec_on   = 1;
            dec_cnt  = 0;
            dec_word = 0;
            gap_q.push_back(hi_run);
        end
        if (tx === 1'b1) hi_run++;
        else             hi_run = 0;
    end

    task automatic push(input int b);
        wr_en = 1'b1;
        din   = b[7:0];
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int limit, input string tag);
        int c;
        c = 0;
        while (rx_q.size() < n && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk(tag, rx_q.size() >= n, 1);
    endtask

    function automatic int rx_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return -1;
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, lat, f, len, errs, zeros, c, b, g, nrx, exp_bit;
        bit found;
        int exp_q[$];
        int ovf[$];
        int fp[$];

        reset = 1'b1;
        wr_en = 1'b0;
        din   = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_empty", tx_empty, 1);
        chk("rst_full", tx_full, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        reset = 1'b0;

        trace.delete();
        rec = 1;
        repeat (1000) @(negedge clk);
        rec = 0;
        zeros = 0;
        foreach (trace[i]) if (!trace[i]) zeros++;
        chk("idle_tx_low_samples", zeros, 0);
        chk("idle_done_ticks", done_cnt, 0);

        // Single byte 0xA5: exact bit waveform from the sampled line.
        d0 = done_cnt;
        rx_q.delete();
        trace.delete();
        rec = 1;
        @(negedge clk);
        wr_en = 1'b1;
        din   = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        chk("a5_empty_after_push", tx_empty, 0);
        lat = 1;
        while (tx !== 1'b0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("a5_start_latency_ok", (lat >= 2 && lat <= 3), 1);
        wait_frames(1, 2000, "a5_frame_seen");
        repeat (100) @(negedge clk);
        rec = 0;
        f = 0;
        found = 0;
        foreach (trace[i]) if (!found && !trace[i]) begin
            found = 1;
            f = i;
        end
        chk("a5_line_fell", found, 1);
        len = 0;
        while (f + len < trace.size() && !trace[f + len]) len++;
        chk("a5_start_len_ok", (len >= 61 && len <= 64), 1);
        for (int j = 0; j <= NB; j++) begin
            exp_bit = (j < NB) ? ((frame_word(8'hA5) >> j) & 1) : 1;
            errs = 0;
            for (int m = 0; m < BITCLK; m++) begin
                if (f + len + BITCLK * j + m >= trace.size()) errs++;
                else if (int'(trace[f + len + BITCLK * j + m]) != exp_bit) errs++;
            end
            chk($sformatf("a5_bit%0d_samples_wrong", j), errs, 0);
        end
        chk("a5_rx_word", rx_at(0), frame_word(8'hA5));
        chk("a5_done_once", done_cnt - d0, 1);

`ifdef UART_TX_PARITY_EN
        rx_q.delete();
        push(8'h07);
        push(8'h03);
        wait_frames(2, 3000, "par_frames_seen");
        chk("par_07_bit", (rx_at(0) >> 8) & 1, 1);
        chk("par_03_bit", (rx_at(1) >> 8) & 1, 0);
        chk("par_07_data", rx_at(0) & 255, 8'h07);
`endif

        // Overflow: one frame in flight, then 0x01..0x05 fill the 4-deep FIFO.
        repeat (20) @(negedge clk);
        rx_q.delete();
        gap_q.delete();
        ovf = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04};
        push(8'hC3);
        repeat (5) @(negedge clk);
        chk("ovf_busy", tx_busy, 1);
        chk("ovf_empty_in_flight", tx_empty, 1);
        for (int i = 1; i <= 5; i++) push(i);
        chk("ovf_full", tx_full, 1);
        wait_frames(5, 5000, "ovf_frames_seen");
        repeat (800) @(negedge clk);
        chk("ovf_frame_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("ovf_rx%0d", i), rx_at(i), frame_word(ovf[i]));
        for (int i = 1; i < 5 && i < gap_q.size(); i++)
            chk($sformatf("ovf_gap%0d", i), gap_q[i], b2b_gap(ovf[i-1]));
        chk("ovf_empty_after", tx_empty, 1);

        // Push into a full FIFO in the cycle the FSM pops the head.
        rx_q.delete();
        fp = '{8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        push(8'h5A);
        repeat (5) @(negedge clk);
        for (int i = 1; i <= 4; i++) push(fp[i]);
        chk("fp_full", tx_full, 1);
        c = 0;
        while (tx_done !== 1'b1 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("fp_done_seen", tx_done, 1);
        @(negedge clk);
        chk("fp_full_at_pop", tx_full, 1);
        push(8'h55);
        chk("fp_full_after", tx_full, 1);
        wait_frames(6, 6000, "fp_frames_seen");
        repeat (800) @(negedge clk);
        chk("fp_frame_count", rx_q.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("fp_rx%0d", i), rx_at(i), frame_word(fp[i]));

        // Reset during data bit 3 of 0xFF with another byte queued.
        rx_q.delete();
        push(8'hFF);
        push(8'h77);
        c = 0;
        while (tx !== 1'b0 && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("rst_mid_fell", tx, 0);
        repeat (BITCLK * 4 + BITCLK / 2) @(negedge clk);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_empty", tx_empty, 1);
        chk("rst_mid_busy", tx_busy, 0);
        reset = 1'b0;
        repeat (1500) @(negedge clk);
        chk("rst_mid_no_done", done_cnt - d0, 0);
        chk("rst_mid_no_frames", rx_q.size(), 0);

        // Random bytes at random spacing, pushed only while the FIFO has room.
        rx_q.delete();
        exp_q.delete();
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            b = $urandom_range(0, 255);
            g = $urandom_range(0, 120);
            repeat (g) @(negedge clk);
            c = 0;
            while (tx_full === 1'b1 && c < 3000) begin
                @(negedge clk);
                c++;
            end
            if (c >= 3000) errs++;
            push(b);
            exp_q.push_back(frame_word(b));
        end
        chk("rnd_full_wait_timeouts", errs, 0);
        wait_frames(16, 16000, "rnd_frames_seen");
        repeat (200) @(negedge clk);
        nrx = rx_q.size();
        chk("rnd_frame_count", nrx, 16);
        for (int i = 0; i < 16; i++) chk($sformatf("rnd_rx%0d", i), rx_at(i), exp_q[i]);

        chk("framing_errors", frame_err, 0);
        chk("done_pulse_wide", done_wide, 0);
        chk("done_vs_frames", done_cnt, frames);
        chk("end_idle_tx", tx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
